// File: rtl/inst_latency_sched.sv
// Tracks in-flight instructions with class-dependent latency and reports completions round-robin.
// Latency: issue at edge t reports after edge t+LAT; report grant is held stable until accepted.
module inst_latency_sched #(
  parameter int UNI_LAT  = 5,
  parameter int MULT_LAT = 10,
  parameter int DIV_LAT  = 15,
  parameter int SLOTS    = 4,
  parameter int TAG_W    = 4,
  parameter int CNT_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [1:0]                 issue_class,
  input  logic [TAG_W-1:0]           issue_tag,
  output logic                       issue_ready,
  output logic                       report_valid,
  input  logic                       report_ready,
  output logic [TAG_W-1:0]           report_tag,
  output logic [1:0]                 report_class,
  output logic [$clog2(SLOTS+1)-1:0] inflight,
  output logic                       busy,
  output logic                       illegal_seen
);
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int INF_W = $clog2(SLOTS + 1);

  logic [SLOTS-1:0] r_occ;
  logic [1:0]       r_cls [SLOTS];
  logic [TAG_W-1:0] r_tag [SLOTS];
  logic [CNT_W-1:0] r_cnt [SLOTS];
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_gnt;
  logic             r_lock;
  logic [INF_W-1:0] r_inflight;
  logic             r_illegal;

  logic [SLOTS-1:0] w_done;
  logic             w_any_free;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_arb_found;
  logic [IDX_W-1:0] w_arb_idx;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [IDX_W-1:0] w_rr_next;
  logic             w_acc;
  logic             w_hs;

  function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] c);
    case (c)
      2'd1:    lat_of = CNT_W'(MULT_LAT);
      2'd2:    lat_of = CNT_W'(DIV_LAT);
      default: lat_of = CNT_W'(UNI_LAT);
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      w_done[i] = r_occ[i] && (r_cnt[i] == '0);
    end
  end

  // Reverse scans so the lowest index (or the nearest to rr_ptr) wins.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_occ[i]) begin
        w_any_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_cand      = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + k) % SLOTS);
      if (w_done[w_cand]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand;
      end
    end
  end

  assign w_gnt_idx    = r_lock ? r_gnt : w_arb_idx;
  assign report_valid = r_lock || w_arb_found;
  assign report_tag   = report_valid ? r_tag[w_gnt_idx] : '0;
  assign report_class = report_valid ? r_cls[w_gnt_idx] : 2'd0;
  assign issue_ready  = w_any_free;
  assign w_acc        = issue_valid && issue_ready;
  assign w_hs         = report_valid && report_ready;
  assign w_rr_next    = (w_gnt_idx == IDX_W'(SLOTS - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
  assign inflight     = r_inflight;
  assign busy         = (r_inflight != '0);
  assign illegal_seen = r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_cls[i] <= 2'd0;
        r_tag[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (w_acc && (w_free_idx == IDX_W'(i))) begin
          r_occ[i] <= 1'b1;
          r_cls[i] <= issue_class;
          r_tag[i] <= issue_tag;
          r_cnt[i] <= lat_of(issue_class);
        end else if (w_hs && (w_gnt_idx == IDX_W'(i))) begin
          r_occ[i] <= 1'b0;
        end else if (r_occ[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // The lock captures the grant shown this cycle so later completions cannot steal it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock     <= 1'b0;
      r_gnt      <= '0;
      r_rr_ptr   <= '0;
      r_inflight <= '0;
      r_illegal  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= w_rr_next;
      end else if (report_valid) begin
        r_lock <= 1'b1;
        r_gnt  <= w_gnt_idx;
      end
      case ({w_acc, w_hs})
        2'b10:   r_inflight <= r_inflight + INF_W'(1);
        2'b01:   r_inflight <= r_inflight - INF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_acc && (issue_class == 2'd3)) begin
        r_illegal <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inst_latency_sched.sv
// Directed bench for inst_latency_sched; expected values are hand-derived from the edge numbering.
module tb_inst_latency_sched;
  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [1:0] issue_class;
  logic [3:0] issue_tag;
  logic       issue_ready;
  logic       report_valid;
  logic       report_ready;
  logic [3:0] report_tag;
  logic [1:0] report_class;
  logic [2:0] inflight;
  logic       busy;
  logic       illegal_seen;

  int n_chk = 0;
  int n_err = 0;

  inst_latency_sched dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_class  (issue_class),
    .issue_tag    (issue_tag),
    .issue_ready  (issue_ready),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .report_tag   (report_tag),
    .report_class (report_class),
    .inflight     (inflight),
    .busy         (busy),
    .illegal_seen (illegal_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    issue_valid  = 1'b0;
    issue_class  = 2'd0;
    issue_tag    = 4'd0;
    report_ready = 1'b0;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic issue(input logic [1:0] cls, input logic [3:0] tag);
    issue_valid = 1'b1;
    issue_class = cls;
    issue_tag   = tag;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic chk_report(input string tag, input int vld, input int t, input int c);
    chk({tag, "_vld"}, int'(report_valid), vld);
    chk({tag, "_tag"}, int'(report_tag), t);
    chk({tag, "_cls"}, int'(report_class), c);
  endtask

  int seen;

  initial begin
    // Reset values
    do_reset();
    chk("rst_ready", int'(issue_ready), 1);
    chk_report("rst_rep", 0, 0, 0);
    chk("rst_inflight", int'(inflight), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_illegal", int'(illegal_seen), 0);

    // Single uni instruction: report visible after edge 5 only
    report_ready = 1'b1;
    issue(2'd0, 4'd3);                       // edge 0
    chk("t1_inflight1", int'(inflight), 1);
    chk("t1_busy1", int'(busy), 1);
    steps(4);                                // after edge 4
    chk("t1_early", int'(report_valid), 0);
    step();                                  // after edge 5
    chk_report("t1_rep", 1, 3, 0);
    step();                                  // after edge 6
    chk("t1_vld_drop", int'(report_valid), 0);
    chk("t1_inflight0", int'(inflight), 0);
    chk("t1_busy0", int'(busy), 0);

    // Mixed classes complete in latency order
    do_reset();
    report_ready = 1'b1;
    issue(2'd0, 4'd1);                       // edge 0
    issue(2'd1, 4'd2);                       // edge 1
    issue(2'd2, 4'd4);                       // edge 2
    chk("t2_peak", int'(inflight), 3);
    steps(3);                                // after edge 5
    chk_report("t2_uni", 1, 1, 0);
    step();                                  // after edge 6
    chk("t2_inflight2", int'(inflight), 2);
    steps(4);                                // after edge 10
    chk("t2_mult_early", int'(report_valid), 0);
    step();                                  // after edge 11
    chk_report("t2_mult", 1, 2, 1);
    steps(5);                                // after edge 16
    chk("t2_div_early", int'(report_valid), 0);
    step();                                  // after edge 17
    chk_report("t2_div", 1, 4, 2);
    step();
    chk("t2_inflight0", int'(inflight), 0);

    // Fill all slots with report_ready low, then drain
    do_reset();
    issue(2'd0, 4'd1);                       // edge 0
    issue(2'd0, 4'd2);
    issue(2'd0, 4'd3);
    issue(2'd0, 4'd4);                       // edge 3
    chk("t3_full_ready", int'(issue_ready), 0);
    chk("t3_full_inflight", int'(inflight), 4);
    issue(2'd0, 4'd15);                      // edge 4, ignored
    chk("t3_ignored", int'(inflight), 4);
    steps(4);                                // after edge 8
    chk_report("t3_d0", 1, 1, 0);
    chk("t3_still_full", int'(issue_ready), 0);
    report_ready = 1'b1;
    step();                                  // after edge 9
    chk("t3_ready_back", int'(issue_ready), 1);
    chk_report("t3_d1", 1, 2, 0);
    step();
    chk_report("t3_d2", 1, 3, 0);
    step();
    chk_report("t3_d3", 1, 4, 0);
    step();
    chk("t3_empty_vld", int'(report_valid), 0);
    chk("t3_empty_inflight", int'(inflight), 0);

    // Simultaneous done in slots 3 and 0 with rr_ptr=3: grant stays on 3, then wraps to 0
    do_reset();
    report_ready = 1'b1;
    issue(2'd1, 4'd5);                       // edge 0 -> slot 0, done after edge 10
    issue(2'd0, 4'd6);                       // edge 1 -> slot 1, done after edge 6
    issue(2'd0, 4'd7);                       // edge 2 -> slot 2, done after edge 7
    steps(2);                                // after edge 4
    issue(2'd0, 4'd8);                       // edge 5 -> slot 3, done after edge 10
    step();                                  // after edge 6
    chk_report("t4_s1", 1, 6, 0);
    step();                                  // after edge 7
    chk_report("t4_s2", 1, 7, 0);
    step();                                  // after edge 8
    report_ready = 1'b0;
    steps(2);                                // after edge 10
    chk_report("t4_hold0", 1, 8, 0);
    step();
    chk_report("t4_hold1", 1, 8, 0);
    step();                                  // after edge 12
    chk_report("t4_hold2", 1, 8, 0);
    report_ready = 1'b1;
    step();                                  // after edge 13
    chk_report("t4_wrap", 1, 5, 1);
    step();
    chk("t4_done_vld", int'(report_valid), 0);

    // Mid-flight reset discards the pending divide
    do_reset();
    report_ready = 1'b1;
    issue(2'd2, 4'd4);                       // edge 0
    steps(7);
    rst = 1'b1;
    #1;
    chk("t5_ready", int'(issue_ready), 1);
    chk_report("t5_rep", 0, 0, 0);
    chk("t5_inflight", int'(inflight), 0);
    chk("t5_busy", int'(busy), 0);
    steps(2);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (report_valid) seen++;
    end
    chk("t5_no_report", seen, 0);

    // Illegal class
    do_reset();
    report_ready = 1'b1;
    issue(2'd3, 4'd9);                       // edge 0
    chk("t6_illegal_set", int'(illegal_seen), 1);
    steps(5);                                // after edge 5
    chk_report("t6_rep", 1, 9, 3);
    step();
    chk("t6_vld_drop", int'(report_valid), 0);
    chk("t6_sticky", int'(illegal_seen), 1);
    rst = 1'b1;
    #1;
    chk("t6_cleared", int'(illegal_seen), 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
